// File: rtl/seq_gen_pkg.sv
// Shared definitions for the nibble sequence generator and its detector partner:
// state encodings, head/tail symbol tables and the default idle symbol.
package seq_gen_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'b0001,
        ST_HEAD = 4'b0010,
        ST_TAIL = 4'b0100,
        ST_FIN  = 4'b1000
    } state_t;

    typedef enum logic {
        PH_HEAD = 1'b0,
        PH_TAIL = 1'b1
    } phase_t;

    localparam logic [2:0] HEAD_LAST = 3'd4;
    localparam logic [2:0] TAIL_LAST = 3'd2;

    localparam logic [3:0] SYM_HEAD [0:4] = '{4'h0, 4'h1, 4'h2, 4'h3, 4'h4};
    localparam logic [3:0] SYM_TAIL [0:2] = '{4'h5, 4'h3, 4'h4};

    localparam logic [3:0] DEF_IDLE_SYM = 4'hF;
    localparam logic [3:0] ERR_MASK     = 4'h8;

endpackage

// File: rtl/seq_sym_rom.sv
// Combinational symbol lookup: (phase, idx) -> symbol, plus a flag marking the
// symbol that closes a pattern. Out-of-range indices saturate to the last entry.
module seq_sym_rom
    import seq_gen_pkg::*;
#(
    parameter int SYM_W = 4
) (
    input  phase_t           phase,
    input  logic [2:0]       idx,
    output logic [SYM_W-1:0] sym,
    output logic             last
);

    logic [2:0] head_idx_s;
    logic [1:0] tail_idx_s;

    // Saturated table lookup for the selected phase
    always_comb begin
        head_idx_s = (idx > HEAD_LAST) ? HEAD_LAST : idx;
        tail_idx_s = (idx > TAIL_LAST) ? 2'd2 : idx[1:0];
        sym        = {SYM_W{1'b0}};
        last       = 1'b0;
        case (phase)
            PH_HEAD: begin
                sym  = SYM_W'(SYM_HEAD[head_idx_s]);
                last = (idx >= HEAD_LAST);
            end
            PH_TAIL: begin
                sym  = SYM_W'(SYM_TAIL[tail_idx_s]);
                last = (idx >= TAIL_LAST);
            end
            default: begin
                sym  = {SYM_W{1'b0}};
                last = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/nibble_seq_gen.sv
// Nibble sequence generator: head 0,1,2,3,4 followed by reps tails of 5,3,4.
// Optional error injection on sym_out is enabled with macro SEQ_GEN_ERR_INJ_EN.
module nibble_seq_gen
    import seq_gen_pkg::*;
#(
    parameter int               SYM_W    = 4,
    parameter int               REP_W    = 4,
    parameter logic [SYM_W-1:0] IDLE_SYM = SYM_W'(DEF_IDLE_SYM)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [REP_W-1:0] reps,
    input  logic             abort,
`ifdef SEQ_GEN_ERR_INJ_EN
    input  logic             err_inj,
`endif
    output logic [SYM_W-1:0] sym_out,
    output logic             sym_vld,
    output logic             busy,
    output logic             done,
    output logic             hit_exp
);

    state_t           state_r, state_s;
    logic [2:0]       idx_r, idx_s;
    logic [REP_W-1:0] reps_left_r, reps_left_s;
    logic             pat_bad_r, pat_bad_s;
    phase_t           phase_s;
    logic             emit_s, new_pat_s, done_s, corrupt_s, hit_s;
    logic [SYM_W-1:0] rom_sym_s, sym_s;
    logic             rom_last_s;

    // Next-state logic; outputs are computed for the symbol about to be registered
    always_comb begin
        state_s     = state_r;
        idx_s       = idx_r;
        reps_left_s = reps_left_r;
        phase_s     = PH_HEAD;
        emit_s      = 1'b0;
        new_pat_s   = 1'b0;
        done_s      = 1'b0;
        if (abort && (state_r != ST_IDLE)) begin
            state_s     = ST_IDLE;
            idx_s       = 3'd0;
            reps_left_s = {REP_W{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (start && !abort) begin
                        state_s     = ST_HEAD;
                        idx_s       = 3'd0;
                        reps_left_s = reps;
                        emit_s      = 1'b1;
                        new_pat_s   = 1'b1;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_HEAD: begin
                    if (idx_r >= HEAD_LAST) begin
                        idx_s = 3'd0;
                        if (reps_left_r != {REP_W{1'b0}}) begin
                            state_s   = ST_TAIL;
                            phase_s   = PH_TAIL;
                            emit_s    = 1'b1;
                            new_pat_s = 1'b1;
                        end else begin
                            state_s = ST_FIN;
                            done_s  = 1'b1;
                        end
                    end else begin
                        idx_s  = idx_r + 3'd1;
                        emit_s = 1'b1;
                    end
                end
                ST_TAIL: begin
                    phase_s = PH_TAIL;
                    if (idx_r >= TAIL_LAST) begin
                        idx_s       = 3'd0;
                        reps_left_s = (reps_left_r != {REP_W{1'b0}}) ?
                                      (reps_left_r - REP_W'(1'b1)) : {REP_W{1'b0}};
                        if (reps_left_r <= REP_W'(1'b1)) begin
                            state_s = ST_FIN;
                            done_s  = 1'b1;
                        end else begin
                            emit_s    = 1'b1;
                            new_pat_s = 1'b1;
                        end
                    end else begin
                        idx_s  = idx_r + 3'd1;
                        emit_s = 1'b1;
                    end
                end
                ST_FIN: begin
                    state_s = ST_IDLE;
                end
                default: begin
                    state_s     = ST_IDLE;
                    idx_s       = 3'd0;
                    reps_left_s = {REP_W{1'b0}};
                end
            endcase
        end
    end

    seq_sym_rom #(.SYM_W(SYM_W)) u_rom (
        .phase (phase_s),
        .idx   (idx_s),
        .sym   (rom_sym_s),
        .last  (rom_last_s)
    );

`ifdef SEQ_GEN_ERR_INJ_EN
    assign corrupt_s = emit_s & err_inj;
`else
    assign corrupt_s = 1'b0;
`endif

    // A corrupted symbol taints the rest of its pattern so its closing hit is dropped
    always_comb begin
        pat_bad_s = emit_s & ((new_pat_s ? 1'b0 : pat_bad_r) | corrupt_s);
        sym_s     = emit_s ? (rom_sym_s ^ (corrupt_s ? SYM_W'(ERR_MASK) : {SYM_W{1'b0}}))
                           : IDLE_SYM;
        hit_s     = emit_s & rom_last_s & ~pat_bad_s;
    end

    // State, counters and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            idx_r       <= 3'd0;
            reps_left_r <= {REP_W{1'b0}};
            pat_bad_r   <= 1'b0;
            sym_out     <= IDLE_SYM;
            sym_vld     <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hit_exp     <= 1'b0;
        end else begin
            state_r     <= state_s;
            idx_r       <= idx_s;
            reps_left_r <= reps_left_s;
            pat_bad_r   <= pat_bad_s;
            sym_out     <= sym_s;
            sym_vld     <= emit_s;
            busy        <= emit_s;
            done        <= done_s;
            hit_exp     <= hit_s;
        end
    end

endmodule

// File: tb/tb_nibble_seq_gen.sv
// Self-checking bench for nibble_seq_gen: directed and randomized sequences
// checked against a symbol-list model of the expected stream.
module tb_nibble_seq_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] reps;
    logic       abort;
    logic [3:0] sym_out;
    logic       sym_vld, busy, done, hit_exp;
`ifdef SEQ_GEN_ERR_INJ_EN
    logic       err_inj;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_seq_gen dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .reps    (reps),
        .abort   (abort),
`ifdef SEQ_GEN_ERR_INJ_EN
        .err_inj (err_inj),
`endif
        .sym_out (sym_out),
        .sym_vld (sym_vld),
        .busy    (busy),
        .done    (done),
        .hit_exp (hit_exp)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_inj(input bit v);
`ifdef SEQ_GEN_ERR_INJ_EN
        err_inj = v;
`else
        if (v) $display("note: error injection not built in");
`endif
    endtask

    task automatic chk_idle(input string tag, input bit exp_done);
        chk({tag, ".sym"},  32'(sym_out), 32'hF);
        chk({tag, ".vld"},  32'(sym_vld), 32'd0);
        chk({tag, ".busy"}, 32'(busy),    32'd0);
        chk({tag, ".done"}, 32'(done),    32'(exp_done));
        chk({tag, ".hit"},  32'(hit_exp), 32'd0);
    endtask

    function automatic int pat_of(input int k);
        return (k < 5) ? 0 : 1 + (k - 5) / 3;
    endfunction

    // Issue one start and follow the whole stream; abort_at/inj_at = -1 disables them
    task automatic run_seq(input int r, input int abort_at, input bit noise, input int inj_at);
        int q[$];
        int n, bad_pat, exp_sym;
        bit exp_hit;
        for (int i = 0; i < 5; i++) q.push_back(i);
        for (int j = 0; j < r; j++) begin
            q.push_back(5); q.push_back(3); q.push_back(4);
        end
        n       = q.size();
        bad_pat = (inj_at >= 0) ? pat_of(inj_at) : -1;
        start = 1'b1;
        reps  = 4'(r);
        set_inj(inj_at == 0);
        tick();
        start = 1'b0;
        set_inj(1'b0);
        for (int k = 0; k < n; k++) begin
            exp_sym = (k == inj_at) ? (q[k] ^ 8) : q[k];
            exp_hit = (q[k] == 4) && (pat_of(k) != bad_pat);
            chk($sformatf("r%0d.k%0d.sym", r, k), 32'(sym_out), 32'(exp_sym));
            chk($sformatf("r%0d.k%0d.vld", r, k), 32'(sym_vld), 32'd1);
            chk($sformatf("r%0d.k%0d.busy", r, k), 32'(busy), 32'd1);
            chk($sformatf("r%0d.k%0d.hit", r, k), 32'(hit_exp), 32'(exp_hit));
            chk($sformatf("r%0d.k%0d.done", r, k), 32'(done), 32'd0);
            if (k == abort_at) begin
                abort = 1'b1;
                tick();
                abort = 1'b0;
                chk_idle($sformatf("abort%0d.a", k), 1'b0);
                tick();
                chk_idle($sformatf("abort%0d.b", k), 1'b0);
                return;
            end
            start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            reps  = 4'($urandom_range(0, 15));
            set_inj((k + 1) == inj_at);
            tick();
            start = 1'b0;
            set_inj(1'b0);
        end
        chk_idle($sformatf("r%0d.fin", r), 1'b1);
        start = noise;
        tick();
        start = 1'b0;
        chk_idle($sformatf("r%0d.post", r), 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;
        reps  = 4'd0;
        set_inj(1'b0);
        #12;
        chk_idle("reset", 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk_idle("post_reset", 1'b0);

        run_seq(0, -1, 1'b0, -1);
        run_seq(2, -1, 1'b1, -1);
        run_seq(2, 7, 1'b0, -1);

        // start and abort together in IDLE: abort wins
        start = 1'b1; abort = 1'b1; reps = 4'd1;
        tick();
        start = 1'b0; abort = 1'b0;
        chk_idle("start_abort.a", 1'b0);
        tick();
        chk_idle("start_abort.b", 1'b0);

        // async reset in the middle of the head
        start = 1'b1; reps = 4'd3;
        tick();
        start = 1'b0;
        tick();
        tick();
        chk("mid_head.sym", 32'(sym_out), 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk_idle("async_rst", 1'b0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
        chk_idle("rst_release", 1'b0);
        run_seq(1, -1, 1'b0, -1);

        for (int i = 0; i < 8; i++) begin
            run_seq($urandom_range(0, 15),
                    ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 4)) : -1,
                    1'b1, -1);
            tick();
        end

`ifdef SEQ_GEN_ERR_INJ_EN
        run_seq(1, -1, 1'b0, 2);
        for (int i = 0; i < 4; i++) begin
            run_seq(3, -1, 1'b1, $urandom_range(0, 13));
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
